// File: rtl/sub_arbiter_if.sv
// Requester-side bus of sub_arbiter: two req/ack operand channels and a shared
// response bus with one valid strobe per requester.
interface sub_arbiter_if #(
  parameter int W = 12
);
  logic         req0;
  logic [W-1:0] a0;
  logic [W-1:0] b0;
  logic         ack0;
  logic         req1;
  logic [W-1:0] a1;
  logic [W-1:0] b1;
  logic         ack1;
  logic         rsp_valid0;
  logic         rsp_valid1;
  logic [W:0]   rsp_data;

  modport master (
    output req0, a0, b0, req1, a1, b1,
    input  ack0, ack1, rsp_valid0, rsp_valid1, rsp_data
  );

  modport slave (
    input  req0, a0, b0, req1, a1, b1,
    output ack0, ack1, rsp_valid0, rsp_valid1, rsp_data
  );
endinterface

// File: rtl/sub_arbiter.sv
// Round-robin sharing of one LAT-cycle pipelined signed subtractor between two
// requesters, with tag tracking, per-requester outstanding limit and op counter.
module sub_arbiter #(
  parameter int W       = 12,
  parameter int LAT     = 3,
  parameter int MAX_OUT = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  sub_arbiter_if.slave     bus,
  output logic [W-1:0]     sub_n1,
  output logic [W-1:0]     sub_n2,
  input  logic [W:0]       sub_result,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam logic [OW-1:0] MAX_C = OW'(MAX_OUT);

  // Handshake: a requester holds req_i with a_i/b_i stable until it sees ack_i
  // high in a cycle; that cycle is the transfer. Responses are strobes with no
  // ready and cannot be stalled.

  logic [OW-1:0]  out_cnt0;
  logic [OW-1:0]  out_cnt1;
  logic           rr_ptr;
  logic [LAT-1:0] tag_valid;
  logic [LAT-1:0] tag_id;

  logic last_valid;
  logic last_id;
  logic rsp0;
  logic rsp1;
  logic elig0;
  logic elig1;
  logic grant;
  logic grant_id;

  assign last_valid = tag_valid[LAT-1];
  assign last_id    = tag_id[LAT-1];
  assign rsp0       = last_valid & ~last_id;
  assign rsp1       = last_valid & last_id;

  // A response retiring this cycle frees its slot for a same-cycle grant.
  assign elig0 = bus.req0 & ~rst & ((out_cnt0 < MAX_C) | rsp0);
  assign elig1 = bus.req1 & ~rst & ((out_cnt1 < MAX_C) | rsp1);

  always_comb begin
    grant    = 1'b0;
    grant_id = 1'b0;
    if (elig0 && elig1) begin
      grant    = 1'b1;
      grant_id = rr_ptr;
    end else if (elig0) begin
      grant    = 1'b1;
      grant_id = 1'b0;
    end else if (elig1) begin
      grant    = 1'b1;
      grant_id = 1'b1;
    end
  end

  assign bus.ack0 = grant & ~grant_id;
  assign bus.ack1 = grant & grant_id;

  always_comb begin
    sub_n1 = '0;
    sub_n2 = '0;
    if (grant) begin
      sub_n1 = grant_id ? bus.a1 : bus.a0;
      sub_n2 = grant_id ? bus.b1 : bus.b0;
    end
  end

  assign bus.rsp_valid0 = rsp0;
  assign bus.rsp_valid1 = rsp1;
  assign bus.rsp_data   = last_valid ? sub_result : '0;
  assign busy           = |tag_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_valid <= '0;
      tag_id    <= '0;
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_id[i]    <= tag_id[i-1];
      end
      tag_valid[0] <= grant;
      tag_id[0]    <= grant_id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (grant) begin
      rr_ptr <= ~grant_id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_cnt0 <= '0;
      out_cnt1 <= '0;
    end else begin
      if (bus.ack0 && !rsp0) begin
        out_cnt0 <= out_cnt0 + 1'b1;
      end else if (rsp0 && !bus.ack0) begin
        out_cnt0 <= out_cnt0 - 1'b1;
      end
      if (bus.ack1 && !rsp1) begin
        out_cnt1 <= out_cnt1 + 1'b1;
      end else if (rsp1 && !bus.ack1) begin
        out_cnt1 <= out_cnt1 - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count <= '0;
    end else if (last_valid) begin
      op_count <= op_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_sub_arbiter.sv
// Directed bench for sub_arbiter: behavioural 3-stage subtractor, scoreboard of
// expected responses filled on each ack and drained on each response strobe.
module tb_sub_arbiter;
  localparam int W     = 12;
  localparam int LAT   = 3;
  localparam int CNT_W = 4;
  localparam int EW    = 32 + 1 + (W + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic [W-1:0]     sub_n1;
  logic [W-1:0]     sub_n2;
  logic [W:0]       sub_result;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  sub_arbiter_if #(.W(W)) bus ();

  sub_arbiter #(.W(W), .LAT(LAT), .MAX_OUT(2), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .sub_n1     (sub_n1),
    .sub_n2     (sub_n2),
    .sub_result (sub_result),
    .busy       (busy),
    .op_count   (op_count)
  );

  // clock / reset-free external subtractor model
  always #5 clk = ~clk;

  logic [W:0] sub_pipe [LAT];
  always @(posedge clk) begin
    sub_pipe[0] <= {sub_n1[W-1], sub_n1} - {sub_n2[W-1], sub_n2};
    for (int i = 1; i < LAT; i++) sub_pipe[i] <= sub_pipe[i-1];
  end
  assign sub_result = sub_pipe[LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  int              n_cmp = 0;
  int              n_bad = 0;
  logic [EW-1:0]   exp_q[$];
  logic [EW-1:0]   mon_e;
  logic [W:0]      last_rsp_data;
  logic            last_rsp_id;

  function automatic logic [W:0] sub_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    return {a[W-1], a} - {b[W-1], b};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // monitor: push on ack, pop and compare on response
  always @(negedge clk) begin
    if (bus.ack0 || bus.ack1) begin
      check("ack_excl", 32'(bus.ack0 & bus.ack1), 32'd0);
      if (bus.ack0) exp_q.push_back({32'(cyc + LAT), 1'b0, sub_ref(bus.a0, bus.b0)});
      if (bus.ack1) exp_q.push_back({32'(cyc + LAT), 1'b1, sub_ref(bus.a1, bus.b1)});
    end
    if (bus.rsp_valid0 || bus.rsp_valid1) begin
      check("rsp_excl", 32'(bus.rsp_valid0 & bus.rsp_valid1), 32'd0);
      check("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("rsp_cycle", cyc, mon_e[EW-1 -: 32]);
        check("rsp_id", 32'(bus.rsp_valid1), 32'(mon_e[W+1]));
        check("rsp_data", 32'(bus.rsp_data), 32'(mon_e[W:0]));
      end
      last_rsp_data = bus.rsp_data;
      last_rsp_id   = bus.rsp_valid1;
    end
  end

  // driver tasks
  task automatic do_op(input bit id, input logic [W-1:0] a, input logic [W-1:0] b);
    logic got;
    @(posedge clk); #1;
    if (id) begin bus.req1 = 1'b1; bus.a1 = a; bus.b1 = b; end
    else    begin bus.req0 = 1'b1; bus.a0 = a; bus.b0 = b; end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = id ? bus.ack1 : bus.ack0;
    end
    check("op_ack", 32'(got), 32'd1);
    @(posedge clk); #1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1; bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (2) @(posedge clk); #1;
    exp_q.delete();
    rst = 1'b0;
  endtask

  task automatic drain(input string tag);
    repeat (LAT + 3) @(negedge clk);
    check(tag, exp_q.size(), 32'd0);
  endtask

  task automatic rand_ops(input bit id);
    if (id) begin bus.a1 = W'($urandom_range(0, 4095)); bus.b1 = W'($urandom_range(0, 4095)); end
    else    begin bus.a0 = W'($urandom_range(0, 4095)); bus.b0 = W'($urandom_range(0, 4095)); end
  endtask

  initial begin
    #200000;
    n_bad++;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  logic [5:0] lim_pat;

  initial begin
    // reset state, with req0 already asserted
    rst = 1'b1;
    bus.req0 = 1'b1; bus.a0 = 12'd5; bus.b0 = 12'd3;
    bus.req1 = 1'b0; bus.a1 = '0;    bus.b1 = '0;
    repeat (2) @(negedge clk);
    check("rst_ack0", 32'(bus.ack0), 32'd0);
    check("rst_n1", 32'(sub_n1), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
    check("rst_rsp", 32'({bus.rsp_valid1, bus.rsp_valid0}), 32'd0);
    check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    @(posedge clk); #1;
    bus.req0 = 1'b0;
    rst = 1'b0;

    // single op: 100 - 30
    do_op(1'b0, 12'd100, 12'd30);
    repeat (3) @(negedge clk);
    check("single_busy_t3", 32'(busy), 32'd1);
    check("single_rsp_valid0", 32'(bus.rsp_valid0), 32'd1);
    @(negedge clk);
    check("single_busy_t4", 32'(busy), 32'd0);
    check("single_op_count", 32'(op_count), 32'd1);
    check("single_data", 32'(last_rsp_data), 32'h0046);

    // extremes
    do_op(1'b1, 12'h800, 12'h7FF);
    repeat (4) @(negedge clk);
    check("ext_min_data", 32'(last_rsp_data), 32'h1001);
    check("ext_min_id", 32'(last_rsp_id), 32'd1);
    do_op(1'b0, 12'h7FF, 12'h800);
    repeat (4) @(negedge clk);
    check("ext_max_data", 32'(last_rsp_data), 32'h0FFF);
    check("ext_max_id", 32'(last_rsp_id), 32'd0);
    drain("ext_drain");

    // simultaneous requests held from reset
    @(posedge clk); #1;
    rst = 1'b1; bus.req0 = 1'b1; bus.req1 = 1'b1;
    rand_ops(1'b0); rand_ops(1'b1);
    repeat (2) @(posedge clk); #1;
    exp_q.delete();
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("sim_grant", 32'({bus.ack1, bus.ack0}), (k % 2) ? 32'd2 : 32'd1);
      @(posedge clk); #1;
      rand_ops(1'(k % 2));
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    drain("sim_drain");

    // outstanding limit with only req0
    apply_reset();
    lim_pat = 6'b011011;
    bus.req0 = 1'b1;
    rand_ops(1'b0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("lim_grant", 32'(bus.ack0), 32'(lim_pat[k]));
      if (k == 3) check("lim_rsp_t3", 32'(bus.rsp_valid0), 32'd1);
      @(posedge clk); #1;
      rand_ops(1'b0);
    end
    bus.req0 = 1'b0;
    drain("lim_drain");

    // reset while two ops are in flight
    apply_reset();
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    rand_ops(1'b0); rand_ops(1'b1);
    @(negedge clk);
    check("mid_grant0", 32'(bus.ack0), 32'd1);
    @(posedge clk); #1;
    bus.req0 = 1'b0;
    @(negedge clk);
    check("mid_grant1", 32'(bus.ack1), 32'd1);
    @(posedge clk); #1;
    bus.req1 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("mid_busy_rst", 32'(busy), 32'd0);
    @(negedge clk);
    check("mid_stale0", 32'(bus.rsp_valid0), 32'd0);
    @(posedge clk); #1;
    exp_q.delete();
    rst = 1'b0;
    bus.req0 = 1'b1;
    rand_ops(1'b0);
    @(negedge clk);
    check("mid_regrant", 32'(bus.ack0), 32'd1);
    check("mid_stale1", 32'(bus.rsp_valid1), 32'd0);
    check("mid_op_count", 32'(op_count), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    bus.req0 = 1'b0;
    drain("mid_drain");
    check("mid_op_count_after", 32'(op_count), 32'd1);

    // op_count wrap at CNT_W=4
    apply_reset();
    for (int k = 0; k < 15; k++)
      do_op(1'($urandom_range(0, 1)), W'($urandom_range(0, 4095)), W'($urandom_range(0, 4095)));
    drain("wrap_drain15");
    check("wrap_15", 32'(op_count), 32'd15);
    do_op(1'b1, W'($urandom_range(0, 4095)), W'($urandom_range(0, 4095)));
    drain("wrap_drain16");
    check("wrap_16", 32'(op_count), 32'd0);
    do_op(1'b0, W'($urandom_range(0, 4095)), W'($urandom_range(0, 4095)));
    drain("wrap_drain17");
    check("wrap_17", 32'(op_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
